// File: rtl/apb_gpio_master.sv
// apb_gpio_master: APB3 initiator turning valid/ready commands into single
// APB transfers towards the GPIO register block. One transfer in flight at a
// time, wait states honoured, slave errors and misaligned addresses reported
// on the response port.
// Optional build macro: APB_MASTER_TIMEOUT_EN adds an ACCESS-phase watchdog
// that forces an error response after TIMEOUT_CYCLES wait cycles.
module apb_gpio_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t            r_state, w_state_nxt;

  logic              r_cmd_ready, w_cmd_ready_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic              r_rsp_err,   w_rsp_err_nxt;
  logic [ADDR_W-1:0] r_paddr,     w_paddr_nxt;
  logic              r_psel,      w_psel_nxt;
  logic              r_penable,   w_penable_nxt;
  logic              r_pwrite,    w_pwrite_nxt;
  logic [DATA_W-1:0] r_pwdata,    w_pwdata_nxt;

  // Command fields captured at acceptance; pure data, never reset.
  logic              r_lat_write;
  logic [ADDR_W-1:0] r_lat_addr;
  logic [DATA_W-1:0] r_lat_wdata;
  logic              w_latch;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
`else
  logic              w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign paddr     = r_paddr;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state and next values of every registered output. The APB pins
  // trail the state by one edge: SETUP raises psel, the first ACCESS cycle
  // raises penable, and pready is only looked at once penable is high.
  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_ready_nxt = r_cmd_ready;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_paddr_nxt     = r_paddr;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_pwrite_nxt    = r_pwrite;
    w_pwdata_nxt    = r_pwdata;
    w_latch         = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    w_cnt_nxt       = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        w_cmd_ready_nxt = 1'b1;
        if (cmd_valid && r_cmd_ready) begin
          w_latch         = 1'b1;
          w_cmd_ready_nxt = 1'b0;
          if (cmd_addr[1:0] != 2'b00) begin
            // Misaligned: answer immediately, bus untouched.
            w_state_nxt     = S_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_rdata_nxt = '0;
          end else begin
            w_state_nxt = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        w_psel_nxt    = 1'b1;
        w_penable_nxt = 1'b0;
        w_paddr_nxt   = r_lat_addr;
        w_pwrite_nxt  = r_lat_write;
        w_pwdata_nxt  = r_lat_write ? r_lat_wdata : '0;
        w_state_nxt   = S_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        w_cnt_nxt     = '0;
`endif
      end
      S_ACCESS: begin
        if (!r_penable) begin
          w_penable_nxt = 1'b1;
        end else if (pready) begin
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = r_lat_write ? '0 : prdata;
          w_rsp_err_nxt   = pslverr;
          w_state_nxt     = S_RESP;
`ifdef APB_MASTER_TIMEOUT_EN
        end else if (r_cnt == CNT_LAST) begin
          // This wait cycle is the last one allowed: abandon the transfer.
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = '0;
          w_rsp_err_nxt   = 1'b1;
          w_state_nxt     = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
`endif
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_cmd_ready_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output registers; reset aborts any transfer without a response.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_paddr     <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
    end else begin
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_paddr     <= w_paddr_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_pwdata    <= w_pwdata_nxt;
    end
  end

  // Capture the accepted command.
  always_ff @(posedge sys_clk) begin
    if (w_latch) begin
      r_lat_write <= cmd_write;
      r_lat_addr  <= cmd_addr;
      r_lat_wdata <= cmd_wdata;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  // Wait-cycle counter for the ACCESS watchdog.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_cnt <= '0;
    else         r_cnt <= w_cnt_nxt;
  end
`endif

endmodule

// File: tb/tb_apb_gpio_master.sv
// Directed testbench for apb_gpio_master: each scenario task drives the
// command/APB sides and checks outputs #1 after the rising edge.
module tb_apb_gpio_master;

  logic        sys_clk;
  logic        sys_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int n_checks = 0;
  int n_errors = 0;

  apb_gpio_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Presents one command for exactly one edge (caller ensures cmd_ready=1).
  task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    step(); step();
    if (cmd_ready !== 1'b0) begin n_errors++; $display("FAIL rst_cmd_ready got %0b want 0", cmd_ready); end
    n_checks++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err} !== 5'b0) begin
      n_errors++; $display("FAIL rst_ctrl got %b want 00000", {psel, penable, pwrite, rsp_valid, rsp_err});
    end
    n_checks++;
    if ({paddr, pwdata, rsp_rdata} !== 96'h0) begin
      n_errors++; $display("FAIL rst_data got %h %h %h want 0", paddr, pwdata, rsp_rdata);
    end
    n_checks++;
    sys_rst = 1'b0;
    step();
    if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL rst_release_cmd_ready got %0b want 1", cmd_ready); end
    n_checks++;
  endtask

  task automatic test_write_zero_wait();
    pready = 1'b1; pslverr = 1'b0; prdata = 32'hDEADBEEF;
    send_cmd(1'b1, 32'h08, 32'hFFFF0000);            // edge 0
    if (cmd_ready !== 1'b0 || psel !== 1'b0) begin
      n_errors++; $display("FAIL wr_e0 got cmd_ready=%0b psel=%0b want 0 0", cmd_ready, psel);
    end
    n_checks++;
    step();                                           // edge 1
    if ({psel, penable, pwrite} !== 3'b101 || paddr !== 32'h08 || pwdata !== 32'hFFFF0000) begin
      n_errors++; $display("FAIL wr_setup got sel/en/wr=%b addr=%h wdata=%h want 101 08 ffff0000",
                           {psel, penable, pwrite}, paddr, pwdata);
    end
    n_checks++;
    step();                                           // edge 2
    if ({psel, penable} !== 2'b11 || rsp_valid !== 1'b0) begin
      n_errors++; $display("FAIL wr_access got sel/en=%b rsp_valid=%0b want 11 0", {psel, penable}, rsp_valid);
    end
    n_checks++;
    step();                                           // edge 3
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || psel !== 1'b0) begin
      n_errors++; $display("FAIL wr_rsp got valid=%0b err=%0b rdata=%h psel=%0b want 1 0 0 0",
                           rsp_valid, rsp_err, rsp_rdata, psel);
    end
    n_checks++;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_errors++; $display("FAIL wr_handshake got rsp_valid=%0b cmd_ready=%0b want 0 1", rsp_valid, cmd_ready);
    end
    n_checks++;
  endtask

  task automatic test_read_wait();
    pready = 1'b0; prdata = 32'h12345678;
    send_cmd(1'b0, 32'h00, 32'hCAFEF00D);
    step(); step();                                   // SETUP, ACCESS entry
    for (int i = 0; i < 3; i++) begin
      step();
      if ({psel, penable, pwrite} !== 3'b110 || paddr !== 32'h0 || pwdata !== 32'h0 || rsp_valid !== 1'b0) begin
        n_errors++; $display("FAIL rd_wait%0d got sel/en/wr=%b addr=%h wdata=%h rsp_valid=%0b want 110 0 0 0",
                             i, {psel, penable, pwrite}, paddr, pwdata, rsp_valid);
      end
      n_checks++;
    end
    pready = 1'b1;
    step();
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678 || rsp_err !== 1'b0) begin
      n_errors++; $display("FAIL rd_rsp got valid=%0b rdata=%h err=%0b want 1 12345678 0",
                           rsp_valid, rsp_rdata, rsp_err);
    end
    n_checks++;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_slverr_backpressure();
    pready = 1'b1; pslverr = 1'b1; prdata = 32'h55AA55AA;
    send_cmd(1'b1, 32'h1C, 32'h0);
    step(); step(); step();
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      n_errors++; $display("FAIL err_rsp got valid=%0b err=%0b rdata=%h want 1 1 0", rsp_valid, rsp_err, rsp_rdata);
    end
    n_checks++;
    pslverr = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'h1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || cmd_ready !== 1'b0 || psel !== 1'b0) begin
        n_errors++; $display("FAIL err_hold%0d got valid=%0b err=%0b cmd_ready=%0b psel=%0b want 1 1 0 0",
                             i, rsp_valid, rsp_err, cmd_ready, psel);
      end
      n_checks++;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_errors++; $display("FAIL err_handshake got rsp_valid=%0b cmd_ready=%0b want 0 1", rsp_valid, cmd_ready);
    end
    n_checks++;
  endtask

  task automatic test_misaligned();
    pready = 1'b1;
    send_cmd(1'b1, 32'h4B, 32'h12341234);
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || psel !== 1'b0) begin
      n_errors++; $display("FAIL mis_rsp got valid=%0b err=%0b rdata=%h psel=%0b want 1 1 0 0",
                           rsp_valid, rsp_err, rsp_rdata, psel);
    end
    n_checks++;
    step();
    if (psel !== 1'b0 || rsp_valid !== 1'b1) begin
      n_errors++; $display("FAIL mis_nobus got psel=%0b rsp_valid=%0b want 0 1", psel, rsp_valid);
    end
    n_checks++;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    if (psel !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_errors++; $display("FAIL mis_done got psel=%0b rsp_valid=%0b cmd_ready=%0b want 0 0 1",
                           psel, rsp_valid, cmd_ready);
    end
    n_checks++;
  endtask

  task automatic test_reset_abort();
    pready = 1'b0;
    send_cmd(1'b0, 32'h18, 32'h0);
    step(); step(); step();                           // SETUP, ACCESS, one wait
    if ({psel, penable} !== 2'b11) begin
      n_errors++; $display("FAIL abort_pre got sel/en=%b want 11", {psel, penable});
    end
    n_checks++;
    sys_rst = 1'b1;
    step();
    if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0000) begin
      n_errors++; $display("FAIL abort_rst got sel/en/rv/cr=%b want 0000", {psel, penable, rsp_valid, cmd_ready});
    end
    n_checks++;
    sys_rst = 1'b0;
    pready = 1'b1;
    step();
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_errors++; $display("FAIL abort_release got cmd_ready=%0b rsp_valid=%0b want 1 0", cmd_ready, rsp_valid);
    end
    n_checks++;
    send_cmd(1'b1, 32'h04, 32'hA5A5A5A5);
    step();
    if ({psel, pwrite} !== 2'b11 || paddr !== 32'h04 || pwdata !== 32'hA5A5A5A5) begin
      n_errors++; $display("FAIL abort_next_setup got sel/wr=%b addr=%h wdata=%h want 11 04 a5a5a5a5",
                           {psel, pwrite}, paddr, pwdata);
    end
    n_checks++;
    step(); step();
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      n_errors++; $display("FAIL abort_next_rsp got valid=%0b err=%0b rdata=%h want 1 0 0", rsp_valid, rsp_err, rsp_rdata);
    end
    n_checks++;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_stuck_slave();
    int k;
    pready = 1'b0; prdata = 32'h0BADF00D;
    send_cmd(1'b0, 32'h00, 32'h0);
    step(); step();
`ifdef APB_MASTER_TIMEOUT_EN
    k = 0;
    while (psel === 1'b1 && k < 200) begin
      step();
      k++;
    end
    if (k !== 16) begin n_errors++; $display("FAIL to_cycles got %0d want 16", k); end
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || penable !== 1'b0) begin
      n_errors++; $display("FAIL to_rsp got valid=%0b err=%0b rdata=%h penable=%0b want 1 1 0 0",
                           rsp_valid, rsp_err, rsp_rdata, penable);
    end
    n_checks++;
`else
    k = 0;
    for (int i = 0; i < 120; i++) begin
      step();
      if ({psel, penable} === 2'b11 && rsp_valid === 1'b0) k++;
    end
    if (k !== 120) begin n_errors++; $display("FAIL stuck_held got %0d cycles want 120", k); end
    n_checks++;
    pready = 1'b1;
    step();
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0BADF00D) begin
      n_errors++; $display("FAIL stuck_rsp got valid=%0b err=%0b rdata=%h want 1 0 0badf00d",
                           rsp_valid, rsp_err, rsp_rdata);
    end
    n_checks++;
`endif
    pready = 1'b1;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_errors++; $display("FAIL stuck_done got rsp_valid=%0b cmd_ready=%0b want 0 1", rsp_valid, cmd_ready);
    end
    n_checks++;
  endtask

  initial begin
    sys_rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b1; pslverr = 1'b0;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slverr_backpressure();
    test_misaligned();
    test_reset_abort();
    test_stuck_slave();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
